// File: rtl/mdu_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide unit.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [MDU_WIDTH-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_t;

  function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] v, input logic sgn);
    return (sgn && v[MDU_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// quo/rem present the value of the current iteration so the caller can capture on done.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = MDU_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 kill,
  input  logic [MDU_WIDTH-1:0] dividend,
  input  logic [MDU_WIDTH-1:0] divisor,
  output logic                 done,
  output logic [MDU_WIDTH-1:0] quo,
  output logic [MDU_WIDTH-1:0] rem
);
  localparam int CW = $clog2(DIV_CYCLES);

  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [MDU_WIDTH-1:0] q_r, r_r, d_r;
  logic [MDU_WIDTH:0]   sh, diff;

  // Dividend bits shift out of q_r into the partial remainder; borrow in diff[MSB] means restore.
  assign sh   = {r_r, q_r[MDU_WIDTH-1]};
  assign diff = sh - {1'b0, d_r};
  assign rem  = diff[MDU_WIDTH] ? sh[MDU_WIDTH-1:0] : diff[MDU_WIDTH-1:0];
  assign quo  = {q_r[MDU_WIDTH-2:0], ~diff[MDU_WIDTH]};
  assign done = busy && (cnt == CW'(DIV_CYCLES-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      cnt  <= '0;
      q_r  <= '0;
      r_r  <= '0;
      d_r  <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q_r  <= dividend;
      r_r  <= '0;
      d_r  <= divisor;
    end else if (busy) begin
      q_r <= quo;
      r_r <= rem;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multi-cycle MULT/MULTU/DIV/DIVU engine with pipeline stall/flush handshake.
// Optional MDU_FAST_PATH_EN: trivial operands complete in one cycle.
module exe_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EXE_Start,
  input  logic [2:0]  EXE_Op,
  input  logic [31:0] EXE_A,
  input  logic [31:0] EXE_B,
  input  logic        EXE_Wr,
  input  logic        EXE_Flush,
  input  logic        EXE_DisWr,
  output logic        DIVMULTBusy,
  output logic        Result_Valid,
  output logic        HILO_We,
  output logic [31:0] Result_Hi,
  output logic [31:0] Result_Lo
);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  mdu_op_t    op;
  mdu_state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] a_q, b_q, res_hi, res_lo, a_mag, b_mag;
  logic [31:0] div_quo, div_rem, q_fix, r_fix;
  logic        sgn_q, is_mul, is_div, sgn_in, issue, fast, div_done;
  logic [63:0] a64, b64, prod, mul_out;

  assign op     = mdu_op_t'(EXE_Op);
  assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign sgn_in = (op == MDU_MULT) || (op == MDU_DIV);
  assign issue  = (state == ST_IDLE) && EXE_Start && (is_mul || is_div) && !EXE_Flush;
  assign a_mag  = mdu_mag(EXE_A, sgn_in);
  assign b_mag  = mdu_mag(EXE_B, sgn_in);

`ifdef MDU_FAST_PATH_EN
  assign fast = is_mul ? (EXE_A == '0 || EXE_B == '0) : (EXE_B != '0 && a_mag < b_mag);
`else
  assign fast = 1'b0;
`endif

  assign DIVMULTBusy  = resetn && !EXE_Flush &&
                        (((state == ST_IDLE) && EXE_Start && (is_mul || is_div)) ||
                         (state == ST_MUL) || (state == ST_DIV));
  assign Result_Valid = (state == ST_DONE);
  assign HILO_We      = (state == ST_DONE) && !EXE_DisWr && !EXE_Flush;
  assign Result_Hi    = res_hi;
  assign Result_Lo    = res_lo;

  // Sign-extending to 64 bits gives the same low 64 product bits as a 33x33 signed multiply.
  assign a64  = {{32{sgn_q & a_q[31]}}, a_q};
  assign b64  = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod = a64 * b64;

  if (MUL_CYCLES == 1) begin : g_mul1
    assign mul_out = prod;
  end else begin : g_mulp
    logic [63:0] stg [MUL_CYCLES-1];
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < MUL_CYCLES-1; i++) stg[i] <= '0;
      end else begin
        stg[0] <= prod;
        for (int i = 1; i < MUL_CYCLES-1; i++) stg[i] <= stg[i-1];
      end
    end
    assign mul_out = stg[MUL_CYCLES-2];
  end

  mdu_div_core #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (issue && is_div && !fast),
    .kill     (EXE_Flush),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  assign q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? -div_quo : div_quo;
  assign r_fix = (sgn_q && a_q[31]) ? -div_rem : div_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (EXE_Flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (issue) begin
          a_q   <= EXE_A;
          b_q   <= EXE_B;
          sgn_q <= sgn_in;
          cnt   <= '0;
          if (fast) begin
            state  <= ST_DONE;
            res_hi <= is_mul ? '0 : EXE_A;
            res_lo <= '0;
          end else begin
            state <= is_mul ? ST_MUL : ST_DIV;
          end
        end
        ST_MUL: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MUL_CYCLES-1)) begin
            state  <= ST_DONE;
            res_hi <= mul_out[63:32];
            res_lo <= mul_out[31:0];
          end
        end
        ST_DIV: if (div_done) begin
          state <= ST_DONE;
          if (b_q == '0) begin
            res_hi <= a_q;
            res_lo <= DIV_BY_ZERO_LO;
          end else begin
            res_hi <= r_fix;
            res_lo <= q_fix;
          end
        end
        ST_DONE: if (EXE_Wr) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected HI/LO, a monitor checks each new result.
module tb_exe_muldiv_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b0;
  logic        EXE_Start = 1'b0, EXE_Wr = 1'b1, EXE_Flush = 1'b0, EXE_DisWr = 1'b0;
  logic [2:0]  EXE_Op = 3'd0;
  logic [31:0] EXE_A = '0, EXE_B = '0;
  logic        DIVMULTBusy, Result_Valid, HILO_We;
  logic [31:0] Result_Hi, Result_Lo;

  exe_muldiv_unit #(.DIV_CYCLES(32), .MUL_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .EXE_Start(EXE_Start), .EXE_Op(EXE_Op),
    .EXE_A(EXE_A), .EXE_B(EXE_B), .EXE_Wr(EXE_Wr), .EXE_Flush(EXE_Flush),
    .EXE_DisWr(EXE_DisWr), .DIVMULTBusy(DIVMULTBusy), .Result_Valid(Result_Valid),
    .HILO_We(HILO_We), .Result_Hi(Result_Hi), .Result_Lo(Result_Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   n_tot = 0, n_pass = 0, res_id = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.id = res_id++; e.hi = hi; e.lo = lo; e.we = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (Result_Valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(Result_Valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("res%0d_hi", e.id), 64'(Result_Hi), 64'(e.hi));
        chk($sformatf("res%0d_lo", e.id), 64'(Result_Lo), 64'(e.lo));
        chk($sformatf("res%0d_we", e.id), 64'(HILO_We), 64'(e.we));
      end
    end
    prev_v <= Result_Valid;
  end

  // Issue one op and wait for the first DONE cycle; returns at that cycle's negedge.
  task automatic issue_wait(input string nm, input mdu_op_t op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat);
    int nb, lat;
    nb = 0; lat = -1;
    @(posedge clk); #1;
    EXE_Start = 1'b1; EXE_Op = op; EXE_A = a; EXE_B = b;
    @(negedge clk);
    chk({nm, "_busy_T"}, 64'(DIVMULTBusy), 64'd1);
    if (DIVMULTBusy) nb++;
    @(posedge clk); #1;
    EXE_Start = 1'b0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (Result_Valid) begin lat = i; break; end
      if (DIVMULTBusy) nb++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
  endtask

  task automatic run_op(input string nm, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] hi, input logic [31:0] lo);
    push(hi, lo);
    issue_wait(nm, op, a, b, exp_lat);
    chk({nm, "_we_done"}, 64'(HILO_We), 64'd1);
    @(negedge clk);
    chk({nm, "_valid_after"}, 64'(Result_Valid), 64'd0);
    chk({nm, "_we_after"}, 64'(HILO_We), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(DIVMULTBusy), 64'd0);
    chk("rst_valid", 64'(Result_Valid), 64'd0);
    chk("rst_we", 64'(HILO_We), 64'd0);
    chk("rst_hi", 64'(Result_Hi), 64'd0);
    chk("rst_lo", 64'(Result_Lo), 64'd0);
    #1 resetn = 1'b1;

    run_op("mult_m2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_zero", MDU_MULT, 32'd0, 32'd5, FAST ? 1 : 3, 32'd0, 32'd0);
    run_op("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7d0", MDU_DIVU, 32'd7, 32'd0, 33, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m7d0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("divu_100d7", MDU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("divu_3d10", MDU_DIVU, 32'd3, 32'd10, FAST ? 1 : 33, 32'd3, 32'd0);

    // Flush a DIVU partway through: no result may appear.
    @(posedge clk); #1;
    EXE_Start = 1'b1; EXE_Op = MDU_DIVU; EXE_A = 32'd1000; EXE_B = 32'd3;
    @(posedge clk); #1;
    EXE_Start = 1'b0;
    repeat (9) @(posedge clk);
    #1 EXE_Flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", 64'(DIVMULTBusy), 64'd0);
    chk("flush_we", 64'(HILO_We), 64'd0);
    @(posedge clk); #1 EXE_Flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 64'(DIVMULTBusy), 64'd0);
    chk("flush_idle_valid", 64'(Result_Valid), 64'd0);
    repeat (40) @(posedge clk);
    run_op("multu_5x6", MDU_MULTU, 32'd5, 32'd6, 3, 32'd0, 32'd30);

    // Start together with Flush is dropped.
    @(posedge clk); #1;
    EXE_Start = 1'b1; EXE_Op = MDU_MULT; EXE_A = 32'd2; EXE_B = 32'd2; EXE_Flush = 1'b1;
    @(negedge clk);
    chk("startflush_busy", 64'(DIVMULTBusy), 64'd0);
    @(posedge clk); #1;
    EXE_Start = 1'b0; EXE_Flush = 1'b0;
    @(negedge clk);
    chk("startflush_noissue", 64'(DIVMULTBusy), 64'd0);

    // Hold in DONE with EXE_Wr low and Start held high.
    EXE_Wr = 1'b0;
    push(32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue_wait("hold_mult", MDU_MULT, 32'd7, 32'hFFFF_FFFD, 3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      EXE_Start = 1'b1; EXE_Op = MDU_MULTU; EXE_A = 32'd1; EXE_B = 32'd1;
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 64'(Result_Valid), 64'd1);
      chk($sformatf("hold%0d_busy", k), 64'(DIVMULTBusy), 64'd0);
      chk($sformatf("hold%0d_res", k), {Result_Hi, Result_Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    @(posedge clk); #1 EXE_DisWr = 1'b1;
    @(negedge clk);
    chk("diswr_we", 64'(HILO_We), 64'd0);
    chk("diswr_valid", 64'(Result_Valid), 64'd1);
    @(posedge clk); #1;
    EXE_DisWr = 1'b0; EXE_Start = 1'b0; EXE_Wr = 1'b1;
    @(negedge clk);
    chk("release_valid", 64'(Result_Valid), 64'd1);
    @(negedge clk);
    chk("release_idle_valid", 64'(Result_Valid), 64'd0);
    chk("release_idle_busy", 64'(DIVMULTBusy), 64'd0);

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    EXE_Start = 1'b1; EXE_Op = MDU_DIV; EXE_A = 32'd50; EXE_B = 32'd5;
    @(posedge clk); #1 EXE_Start = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_busy", 64'(DIVMULTBusy), 64'd0);
    chk("arst_valid", 64'(Result_Valid), 64'd0);
    chk("arst_we", 64'(HILO_We), 64'd0);
    chk("arst_res", {Result_Hi, Result_Lo}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("arst_stays_idle", 64'(Result_Valid), 64'd0);
    run_op("post_rst_multu", MDU_MULTU, 32'd9, 32'd9, FAST ? 3 : 3, 32'd0, 32'd81);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine in the EXE stage.
- Generates the DIVMULTBusy stall request consumed by pipeline control, and obeys that control's EXE_Wr, EXE_Flush and EXE_DisWr outputs.
- Produces 64-bit HI/LO results for MULT/MULTU/DIV/DIVU and holds each result until the EXE stage advances.

Parameters:
- DIV_CYCLES, 32, number of radix-2 restoring-division iterations (must equal the operand width).
- MUL_CYCLES, 2, pipelined multiplier latency in cycles (>=1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- EXE_Start  in  1  valid mul/div instruction present in EXE this cycle.
- EXE_Op  in  3  mdu_op_t: MDU_NONE / MDU_MULT / MDU_MULTU / MDU_DIV / MDU_DIVU.
- EXE_A  in  32  rs operand.
- EXE_B  in  32  rt operand.
- EXE_Wr  in  1  EXE stage advances this cycle (pipeline control).
- EXE_Flush  in  1  kill the EXE-stage instruction (pipeline control).
- EXE_DisWr  in  1  HILO write disable (pipeline control).
- DIVMULTBusy  out  1  stall request to pipeline control.
- Result_Valid  out  1  Result_Hi/Result_Lo valid.
- HILO_We  out  1  HILO write enable.
- Result_Hi  out  32  remainder (div) / product[63:32].
- Result_Lo  out  32  quotient (div) / product[31:0].

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, operand and result registers 0; all outputs 0.
- Reset mid-operation aborts the operation immediately.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - EXE_Start=1, EXE_Op!=MDU_NONE and EXE_Flush=0 → latch operands and op, counter=0.
  - Go to MUL or DIV according to the op.
- DIVMULTBusy is combinational: (IDLE & EXE_Start & op!=NONE) | MUL | DIV, forced 0 when EXE_Flush=1. Busy therefore asserts in the issue cycle T.
- MUL:
  - Operands are sign- or zero-extended to 33 bits; the product is registered through MUL_CYCLES stages.
  - After MUL_CYCLES cycles → DONE. DONE is first visible at T+MUL_CYCLES+1.
- DIV:
  - Works on magnitudes |A| and |B| (signed op) or raw values (unsigned op).
  - One restoring iteration per cycle; after DIV_CYCLES iterations → DONE. DONE is first visible at T+DIV_CYCLES+1.
  - Sign fix-up is applied when writing the result registers: quotient sign = A[31]^B[31]; remainder sign = A[31].
- Division special cases:
  - B=0: Lo=32'hFFFF_FFFF, Hi=A (both signed and unsigned).
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: Lo=32'h8000_0000, Hi=0.
- DONE:
  - Result_Valid=1, DIVMULTBusy=0, HILO_We = ~EXE_DisWr.
  - Stays in DONE (results held stable) until EXE_Wr=1, then → IDLE.
  - EXE_Start is ignored in DONE, so the same instruction is never re-issued while EXE is stalled by a higher-priority request.
- EXE_Flush=1 in any state:
  - Next state IDLE, counter cleared, Result_Valid=0 next cycle.
  - HILO_We=0 in the flush cycle itself.
  - A Start in the same cycle as Flush is ignored.
- EXE_DisWr=1 while in MUL/DIV: the computation continues; only HILO_We is masked.
- No back-to-back issue: the earliest next issue is the cycle after leaving DONE.

Optional Feature:
- Macro: MDU_FAST_PATH_EN.
- Defined:
  - In IDLE at issue, if (mul and A==0 or B==0) or (div and B!=0 and |A|<|B|), the unit goes straight to DONE at T+1.
  - Fast-path results: mul gives Hi=Lo=0; div gives Lo=0, Hi=A.
  - DIVMULTBusy is still 1 in cycle T.
- Undefined: full latency always applies. Results are bit-identical either way.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op_t enum, mdu_state_t enum.
  - Constants DIV_BY_ZERO_LO = 32'hFFFF_FFFF and MDU_WIDTH = 32.
- Sub-module mdu_div_core:
  - Iterative restoring divider with start / done and unsigned 32-bit operands.
  - The top level does the sign handling, the multiplier pipeline and the FSM.

Test Plan:
- MULT A=32'hFFFF_FFFE(-2), B=3, EXE_Wr=1 at DONE → Busy high cycles T..T+2; DONE at T+3; Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFFA; HILO_We=1 for one cycle.
- DIV A=-7, B=2 → Busy for 33 cycles; Lo=32'hFFFF_FFFD(-3), Hi=32'hFFFF_FFFF(-1). DIVU 7/0 → Lo=32'hFFFF_FFFF, Hi=7.
- DIV 32'h8000_0000 / -1 → Lo=32'h8000_0000, Hi=0, no hang.
- DIVU in progress, EXE_Flush at iteration 10 → Busy=0 that cycle; IDLE next cycle; no Result_Valid/HILO_We; a following MULTU 5×6 gives Lo=30.
- DONE with EXE_Wr=0 for 4 cycles → Result_Valid stays 1 and results stable; Start held high causes no restart; EXE_Wr=1 → IDLE. With EXE_DisWr=1 in DONE → HILO_We=0, Result_Valid=1.
- Under MDU_FAST_PATH_EN: DIVU 3/10 → DONE at T+1, Lo=0, Hi=3. Async resetn pulse mid-DIV → all outputs 0 immediately.
